// File: rtl/q3_pkg.sv
// Shared types and helpers for the Q3 frame serializer.
// Holds the transmit FSM states, frame constants and the parity function.
package q3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int PAYLOAD_W  = 7;
    localparam int FRAME_BITS = 10;

    function automatic logic even_parity(input logic [PAYLOAD_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/q3_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter.
// A pop on a full FIFO frees the slot that a same-edge push fills.
module q3_sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/q3_frame_serializer.sv
// Captures changed valid selector words into a FIFO and sends each
// as start, 7 data bits LSB-first, even parity and stop on tx.
module q3_frame_serializer
    import q3_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_word,
    output logic                        tx,
    output logic                        busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(PAYLOAD_W - 1);

    state_e                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [PAYLOAD_W-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic [PAYLOAD_W-1:0]   last_payload_q, last_payload_d;
    logic                   first_seen_q, first_seen_d;
    logic                   overflow_q, overflow_d;

    logic                   push, pop, f_full, f_empty;
    logic [PAYLOAD_W-1:0]   f_dout;

    q3_sync_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_word[PAYLOAD_W-1:0]),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (fifo_count)
    );

    // A repeated payload is a held selector output, not a new word.
    always_comb begin
        push = in_word[7] &&
               (!first_seen_q || in_word[PAYLOAD_W-1:0] != last_payload_q);
        pop  = (state_q == IDLE) && !f_empty;
        last_payload_d = push ? in_word[PAYLOAD_W-1:0] : last_payload_q;
        first_seen_d   = first_seen_q | push;
        overflow_d     = overflow_q | (push && f_full && !pop);
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        if (state_q == IDLE) begin
            if (pop) begin
                shift_d = f_dout;
                par_d   = even_parity(f_dout);
                state_d = START;
                baud_d  = '0;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end
        end else if (baud_q != BAUD_MAX) begin
            baud_d = baud_q + BW'(1);
        end else begin
            baud_d = '0;
            unique case (state_q)
                START: begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
                DATA: begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[PAYLOAD_W-1:1]};
                        tx_d      = shift_q[1];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            baud_q         <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            par_q          <= 1'b0;
            tx_q           <= 1'b1;
            busy_q         <= 1'b0;
            last_payload_q <= '0;
            first_seen_q   <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            baud_q         <= baud_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            tx_q           <= tx_d;
            busy_q         <= busy_d;
            last_payload_q <= last_payload_d;
            first_seen_q   <= first_seen_d;
            overflow_q     <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_full = f_full;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_q3_frame_serializer.sv
// Scoreboard bench for q3_frame_serializer: expected payloads are queued
// at stimulus time and a tx frame decoder pops and compares them.
module tb_q3_frame_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_word = 8'h00;
    logic       tx, busy, fifo_full, overflow;
    logic [2:0] fifo_count;

    int         vectors = 0;
    int         errors = 0;
    int         frames_done = 0;
    logic [6:0] exp_q[$];

    q3_frame_serializer #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_word    (in_word),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Frame decoder: offset 0 is the first falling clock edge after tx
    // drops; bit k is sampled at offset 4k+1.
    logic       mon_active = 1'b0;
    int         mon_off = 0;
    logic [9:0] mon_bits;
    logic [6:0] mon_exp;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_off = 0;
            end
        end else begin
            mon_off++;
            if (mon_off % 4 == 1) mon_bits[mon_off/4] = tx;
            if (mon_off == 37) begin
                mon_active = 1'b0;
                frames_done++;
                check("busy_in_stop", busy, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", mon_bits[7:1], 32'hFFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame_start", mon_bits[0], 0);
                    check("frame_payload", mon_bits[7:1], mon_exp);
                    check("frame_parity", mon_bits[8], ^mon_exp);
                    check("frame_stop", mon_bits[9], 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0 && !busy && !mon_active) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, done, 1);
    endtask

    initial begin : stim
        int         bad;
        int         bc;
        int         f0;
        logic       got;
        logic [6:0] pl4 [6];
        logic [6:0] pl6 [5];
        pl4 = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};
        pl6 = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05};

        // 1: reset state and quiet idle
        tick(2);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_full", fifo_full, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 ||
                overflow !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // 2: single word, latency and busy width
        in_word = 8'hC5;
        exp_q.push_back(7'h45);
        @(negedge clk);
        check("t2_tx_before", tx, 1);
        check("t2_count_push", fifo_count, 1);
        in_word = 8'h00;
        @(negedge clk);
        check("t2_tx_fall", tx, 0);
        check("t2_busy_rise", busy, 1);
        check("t2_count_pop", fifo_count, 0);
        bc = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) bc++;
            else break;
        end
        check("t2_busy_cycles", bc, 40);
        wait_idle("t2_drain", 20);

        // 3: held word sends one frame, a new one sends another
        do_reset();
        f0 = frames_done;
        in_word = 8'hC5;
        exp_q.push_back(7'h45);
        tick(100);
        check("t3_one_frame", frames_done - f0, 1);
        in_word = 8'h81;
        exp_q.push_back(7'h01);
        tick(50);
        check("t3_second_frame", frames_done - f0, 2);
        in_word = 8'h00;
        wait_idle("t3_drain", 20);

        // 4: burst of six distinct words overflows a depth-4 FIFO
        tick(5);
        f0 = frames_done;
        for (int i = 0; i < 6; i++) begin
            in_word = {1'b1, pl4[i]};
            if (i < 5) exp_q.push_back(pl4[i]);
            @(negedge clk);
            if (i == 4) check("t4_full_after5", fifo_full, 1);
            if (i == 5) begin
                check("t4_overflow", overflow, 1);
                check("t4_count", fifo_count, 4);
            end
        end
        in_word = 8'h00;
        wait_idle("t4_drain", 400);
        check("t4_frames", frames_done - f0, 5);
        check("t4_overflow_sticky", overflow, 1);

        // 5: asynchronous reset during data bit 3
        do_reset();
        check("t5_overflow_clr", overflow, 0);
        in_word = 8'hAA;
        exp_q.push_back(7'h2A);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        check("t5_start_seen", got, 1);
        tick(17);
        f0 = frames_done;
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_tx", tx, 1);
        check("t5_async_busy", busy, 0);
        check("t5_async_count", fifo_count, 0);
        exp_q.delete();
        exp_q.push_back(7'h2A);
        @(negedge clk);
        rst_n = 1'b1;
        tick(50);
        check("t5_repush_frame", frames_done - f0, 1);
        in_word = 8'h00;
        wait_idle("t5_drain", 20);

        // 6: push on the pop edge while full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_word = {1'b1, pl6[i]};
            exp_q.push_back(pl6[i]);
            @(negedge clk);
        end
        check("t6_full", fifo_full, 1);
        check("t6_count_full", fifo_count, 4);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_busy_fall", got, 1);
        in_word = 8'h86;
        exp_q.push_back(7'h06);
        @(negedge clk);
        check("t6_count_kept", fifo_count, 4);
        check("t6_still_full", fifo_full, 1);
        check("t6_no_overflow", overflow, 0);
        in_word = 8'h00;
        wait_idle("t6_drain", 400);
        check("t6_overflow_end", overflow, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
